// File: rtl/crossy_pkg.sv
// Shared definitions for the Crossy key polling fabric: FSM states and PIO register map.
package crossy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LAT,
        CAP
    } key_poll_state_t;

    // Board keys pull low when pressed.
    localparam bit KEY_ACTIVE_LOW = 1'b1;

    localparam int PIO_DATA_OFS = 0;

endpackage

// File: rtl/crossy_key_debounce.sv
// One key bit: counts consecutive disagreeing polls and commits a new stable level
// after DEBOUNCE_N of them, emitting a one-cycle press or release pulse on the commit.
module crossy_key_debounce
    import crossy_pkg::*;
#(
    parameter int DEBOUNCE_N = 3,
    parameter bit ACTIVE_LOW = KEY_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample,
    input  logic sample_valid,
    output logic stable,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);
    // Raw level of a key that is not being pressed.
    localparam logic IDLE_LEVEL = ACTIVE_LOW;

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable        <= IDLE_LEVEL;
            cnt_reg       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sample_valid) begin
                if (sample == stable) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    stable  <= sample;
                    cnt_reg <= '0;
                    if (sample != IDLE_LEVEL) begin
                        press_pulse <= 1'b1;
                    end else begin
                        release_pulse <= 1'b1;
                    end
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/crossy_key_poll_master.sv
// Avalon-MM read initiator that periodically polls the KEY PIO data register and
// hands each captured sample to a per-bit debouncer for the game logic.
module crossy_key_poll_master
    import crossy_pkg::*;
#(
    parameter int KEY_W        = 2,
    parameter int ADDR_W       = 2,
    parameter int POLL_ADDR    = PIO_DATA_OFS,
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1,
    parameter int DEBOUNCE_N   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [KEY_W-1:0]  key_down,
    output logic [KEY_W-1:0]  key_press,
    output logic [KEY_W-1:0]  key_release,
    output logic              poll_strobe
);

    localparam int TIMER_W = $clog2(POLL_DIV + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);

    key_poll_state_t    state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [LAT_W-1:0]   lat_cnt_reg;
    logic [KEY_W-1:0]   sample_reg;
    logic               sample_valid_reg;
    logic [KEY_W-1:0]   stable_bits;

    // Only the key bits of the data register matter.
    logic unused_readdata;
    assign unused_readdata = ^(avm_readdata >> KEY_W);

    assign avm_address = ADDR_W'(POLL_ADDR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            timer_reg        <= '0;
            lat_cnt_reg      <= '0;
            avm_read         <= 1'b0;
            sample_reg       <= '1;
            sample_valid_reg <= 1'b0;
            poll_strobe      <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            // Debouncer outputs settle on the same edge that leaves CAP.
            poll_strobe      <= (state_reg == CAP);
            case (state_reg)
                IDLE: begin
                    if (!enable) begin
                        timer_reg <= '0;
                    end else if (timer_reg == TIMER_LAST) begin
                        timer_reg <= '0;
                        avm_read  <= 1'b1;
                        state_reg <= REQ;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                REQ: begin
                    // Enable is ignored here so an issued read is never dropped.
                    if (!avm_waitrequest) begin
                        avm_read    <= 1'b0;
                        lat_cnt_reg <= LAT_W'(1);
                        state_reg   <= LAT;
                    end
                end
                LAT: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        sample_reg       <= avm_readdata[KEY_W-1:0];
                        sample_valid_reg <= 1'b1;
                        state_reg        <= CAP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                end
                CAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
            crossy_key_debounce #(
                .DEBOUNCE_N (DEBOUNCE_N),
                .ACTIVE_LOW (KEY_ACTIVE_LOW)
            ) u_debounce (
                .clk           (clk),
                .reset_n       (reset_n),
                .sample        (sample_reg[gi]),
                .sample_valid  (sample_valid_reg),
                .stable        (stable_bits[gi]),
                .press_pulse   (key_press[gi]),
                .release_pulse (key_release[gi])
            );
            assign key_down[gi] = KEY_ACTIVE_LOW ? ~stable_bits[gi] : stable_bits[gi];
        end
    endgenerate

endmodule

// File: tb/tb_crossy_key_poll_master.sv
// Bench for crossy_key_poll_master: a registered PIO responder model, a scoreboard fed
// at each read acceptance and drained on each poll_strobe, plus scenario tasks.
module tb_crossy_key_poll_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [1:0]  key_down;
    logic [1:0]  key_press;
    logic [1:0]  key_release;
    logic        poll_strobe;

    logic [1:0]  key_raw = 2'b11;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cycle = 0;

    typedef struct packed {
        logic [1:0] down;
        logic [1:0] press;
        logic [1:0] rel;
    } exp_t;
    exp_t sb_q[$];

    logic [1:0] m_stable = 2'b11;
    int         m_streak[2];
    int         strobe_total = 0;
    int         read_cycles_total = 0;
    int         press_events = 0;
    int         release_events = 0;
    logic [1:0] last_press = 2'b00;
    logic [1:0] last_release = 2'b00;

    crossy_key_poll_master #(
        .KEY_W        (2),
        .ADDR_W       (2),
        .POLL_ADDR    (0),
        .POLL_DIV     (4),
        .READ_LATENCY (1),
        .DEBOUNCE_N   (3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .key_down        (key_down),
        .key_press       (key_press),
        .key_release     (key_release),
        .poll_strobe     (poll_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Responder: key data only in the cycle after acceptance, inverted junk otherwise.
    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest)
            avm_readdata <= {30'h15555555, key_raw};
        else
            avm_readdata <= {30'h0, ~key_raw};
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            m_stable = 2'b11;
            m_streak[0] = 0;
            m_streak[1] = 0;
        end else begin
            if (avm_read) begin
                read_cycles_total++;
                check_cnt++;
                if (avm_address !== 2'd0)
                    $display("FAIL read_address: got %0d expected 0", avm_address);
                else
                    pass_cnt++;
            end
            if (avm_read && !avm_waitrequest) begin
                exp_t e;
                e = '0;
                for (int i = 0; i < 2; i++) begin
                    if (key_raw[i] != m_stable[i]) begin
                        m_streak[i]++;
                        if (m_streak[i] == 3) begin
                            m_stable[i] = key_raw[i];
                            m_streak[i] = 0;
                            if (key_raw[i] == 1'b0) e.press[i] = 1'b1;
                            else e.rel[i] = 1'b1;
                        end
                    end else begin
                        m_streak[i] = 0;
                    end
                end
                e.down = ~m_stable;
                sb_q.push_back(e);
            end
            if (poll_strobe) begin
                strobe_total++;
                check_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected_strobe: got poll_strobe expected no pending poll at cycle %0d", cycle);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if ({key_down, key_press, key_release} !== {e.down, e.press, e.rel})
                        $display("FAIL sb_poll: got down=%b press=%b release=%b expected down=%b press=%b release=%b at cycle %0d",
                                 key_down, key_press, key_release, e.down, e.press, e.rel, cycle);
                    else
                        pass_cnt++;
                end
            end else begin
                check_cnt++;
                if ((key_press !== 2'b00) || (key_release !== 2'b00))
                    $display("FAIL stray_strobe: got press=%b release=%b expected 00/00 at cycle %0d",
                             key_press, key_release, cycle);
                else
                    pass_cnt++;
            end
            if (key_press != 2'b00) begin
                press_events++;
                last_press = key_press;
            end
            if (key_release != 2'b00) begin
                release_events++;
                last_release = key_release;
            end
        end
    end

    task automatic wait_strobe(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (poll_strobe) begin
                t = cycle;
                break;
            end
        end
        if (t < 0) begin
            check_cnt++;
            $display("FAIL strobe_timeout: got no poll_strobe expected one within %0d cycles", budget);
        end
    endtask

    task automatic polls(input int n);
        int t;
        repeat (n) wait_strobe(40, t);
    endtask

    task automatic wait_read();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (avm_read) break;
        end
        if (!avm_read) begin
            check_cnt++;
            $display("FAIL read_timeout: got avm_read=0 expected 1 within 40 cycles");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if (avm_read !== 1'b0) $display("FAIL reset_read: got %b expected 0", avm_read);
        else pass_cnt++;
        check_cnt++;
        if (avm_address !== 2'd0) $display("FAIL reset_address: got %0d expected 0", avm_address);
        else pass_cnt++;
        check_cnt++;
        if (key_down !== 2'b00) $display("FAIL reset_key_down: got %b expected 00", key_down);
        else pass_cnt++;
        check_cnt++;
        if ({key_press, key_release, poll_strobe} !== 5'b0)
            $display("FAIL reset_strobes: got %b expected 00000", {key_press, key_release, poll_strobe});
        else pass_cnt++;
        reset_n = 1'b1;
    endtask

    task automatic test_idle_polls();
        int t0, t1, t2, r0;
        key_raw = 2'b11;
        enable = 1'b1;
        wait_strobe(40, t0);
        r0 = read_cycles_total;
        wait_strobe(40, t1);
        check_cnt++;
        if (t1 - t0 != 7) $display("FAIL idle_period: got %0d expected 7", t1 - t0);
        else pass_cnt++;
        check_cnt++;
        if (read_cycles_total - r0 != 1) $display("FAIL idle_read_width: got %0d expected 1", read_cycles_total - r0);
        else pass_cnt++;
        wait_strobe(40, t2);
        check_cnt++;
        if (t2 - t1 != 7) $display("FAIL idle_period2: got %0d expected 7", t2 - t1);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ((key_down !== 2'b00) || (press_events != 0) || (release_events != 0))
            $display("FAIL idle_keys: got down=%b presses=%0d releases=%0d expected 00/0/0",
                     key_down, press_events, release_events);
        else pass_cnt++;
    endtask

    task automatic test_press();
        int p0;
        p0 = press_events;
        key_raw = 2'b10;
        polls(2);
        check_cnt++;
        if (key_down !== 2'b00) $display("FAIL press_early: got %b expected 00", key_down);
        else pass_cnt++;
        polls(1);
        check_cnt++;
        if ({key_press, key_down} !== 4'b0101)
            $display("FAIL press_third: got press=%b down=%b expected 01/01", key_press, key_down);
        else pass_cnt++;
        polls(1);
        @(negedge clk);
        check_cnt++;
        if ((press_events - p0 != 1) || (last_press !== 2'b01) || (key_down !== 2'b01))
            $display("FAIL press_once: got events=%0d last=%b down=%b expected 1/01/01",
                     press_events - p0, last_press, key_down);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int r0;
        r0 = release_events;
        key_raw = 2'b11;
        polls(2);
        key_raw = 2'b10;
        polls(2);
        check_cnt++;
        if ((key_down !== 2'b01) || (release_events != r0))
            $display("FAIL glitch_hold: got down=%b releases=%0d expected 01/0", key_down, release_events - r0);
        else pass_cnt++;
        key_raw = 2'b11;
        polls(2);
        check_cnt++;
        if (key_down !== 2'b01) $display("FAIL release_early: got %b expected 01", key_down);
        else pass_cnt++;
        polls(1);
        check_cnt++;
        if ({key_release, key_down} !== 4'b0100)
            $display("FAIL release_third: got release=%b down=%b expected 01/00", key_release, key_down);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ((release_events - r0 != 1) || (last_release !== 2'b01))
            $display("FAIL release_once: got events=%0d last=%b expected 1/01", release_events - r0, last_release);
        else pass_cnt++;
    endtask

    task automatic test_both();
        key_raw = 2'b00;
        polls(2);
        check_cnt++;
        if (key_down !== 2'b00) $display("FAIL both_early: got %b expected 00", key_down);
        else pass_cnt++;
        polls(1);
        check_cnt++;
        if ({key_press, key_down} !== 4'b1111)
            $display("FAIL both_press: got press=%b down=%b expected 11/11", key_press, key_down);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (key_press !== 2'b00) $display("FAIL both_press_width: got %b expected 00", key_press);
        else pass_cnt++;
        key_raw = 2'b11;
        polls(3);
        check_cnt++;
        if ({key_release, key_down} !== 4'b1100)
            $display("FAIL both_release: got release=%b down=%b expected 11/00", key_release, key_down);
        else pass_cnt++;
    endtask

    task automatic test_waitrequest();
        int t0, t1;
        key_raw = 2'b10;
        wait_strobe(40, t0);
        wait_read();
        avm_waitrequest = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_cnt++;
            if ({avm_read, avm_address} !== 3'b100)
                $display("FAIL stall_hold: got read=%b addr=%0d expected 1/0", avm_read, avm_address);
            else pass_cnt++;
        end
        avm_waitrequest = 1'b0;
        wait_strobe(40, t1);
        check_cnt++;
        if (t1 - t0 != 12) $display("FAIL stall_period: got %0d expected 12", t1 - t0);
        else pass_cnt++;
        polls(2);
        check_cnt++;
        if (key_down !== 2'b01) $display("FAIL stall_press: got %b expected 01", key_down);
        else pass_cnt++;
    endtask

    task automatic test_enable_lat();
        int s0, r0;
        wait_read();
        @(posedge clk);
        #1;
        enable = 1'b0;
        s0 = strobe_total;
        r0 = read_cycles_total;
        repeat (30) @(negedge clk);
        check_cnt++;
        if (strobe_total - s0 != 1) $display("FAIL disable_strobes: got %0d expected 1", strobe_total - s0);
        else pass_cnt++;
        check_cnt++;
        if (read_cycles_total != r0) $display("FAIL disable_reads: got %0d expected 0", read_cycles_total - r0);
        else pass_cnt++;
    endtask

    task automatic test_reset_req();
        enable = 1'b1;
        key_raw = 2'b00;
        polls(3);
        check_cnt++;
        if (key_down !== 2'b11) $display("FAIL pre_reset_down: got %b expected 11", key_down);
        else pass_cnt++;
        wait_read();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_cnt++;
        if ({avm_read, avm_address, key_down, key_press, key_release, poll_strobe} !== 10'b0)
            $display("FAIL reset_mid_req: got read=%b addr=%0d down=%b press=%b release=%b strobe=%b expected all 0",
                     avm_read, avm_address, key_down, key_press, key_release, poll_strobe);
        else pass_cnt++;
        key_raw = 2'b11;
        reset_n = 1'b1;
        polls(1);
        check_cnt++;
        if (key_down !== 2'b00) $display("FAIL post_reset_down: got %b expected 00", key_down);
        else pass_cnt++;
    endtask

    initial begin
        m_streak[0] = 0;
        m_streak[1] = 0;
        test_reset();
        test_idle_polls();
        test_press();
        test_glitch();
        test_both();
        test_waitrequest();
        test_enable_lat();
        test_reset_req();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
